// File: rtl/regfile_sequencer_pkg.sv
// rtl/regfile_sequencer_pkg.sv - shared widths, opcode and state enums
package regfile_sequencer_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_MOV  = 3'd6,
        OP_MOVI = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_EXEC   = 3'd2,
        S_WRITE  = 3'd3,
        S_RETIRE = 3'd4
    } state_e;
endpackage

// File: rtl/regfile_sequencer_if.sv
// rtl/regfile_sequencer_if.sv - instruction handshake and register-file port bundle
interface regfile_sequencer_if #(
    parameter int DATA_W = regfile_sequencer_pkg::DATA_W,
    parameter int ADDR_W = regfile_sequencer_pkg::ADDR_W
);
    logic              ins_valid;
    logic              ins_ready;
    logic [2:0]        ins_op;
    logic [ADDR_W-1:0] ins_rd;
    logic [ADDR_W-1:0] ins_rs1;
    logic [ADDR_W-1:0] ins_rs2;
    logic [DATA_W-1:0] ins_imm;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] ra3;
    logic [DATA_W-1:0] wd3;
    logic              we3;

    modport slave (
        input  ins_valid, ins_op, ins_rd, ins_rs1, ins_rs2, ins_imm, rd1, rd2,
        output ins_ready, ra1, ra2, ra3, wd3, we3
    );

    modport master (
        output ins_valid, ins_op, ins_rd, ins_rs1, ins_rs2, ins_imm, rd1, rd2,
        input  ins_ready, ra1, ra2, ra3, wd3, we3
    );
endinterface

// File: rtl/regfile_sequencer_alu.sv
// rtl/regfile_sequencer_alu.sv - combinational ALU for the sequencer EXEC stage
module seq_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = regfile_sequencer_pkg::DATA_W
) (
    input  op_e               i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // top bit of the widened difference is the unsigned borrow (a < b)
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = w_diff[DATA_W];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_MOV:  o_result = i_a;
            OP_MOVI: o_result = i_imm;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);
endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - five-state instruction sequencer driving a 3-port register file
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = regfile_sequencer_pkg::DATA_W,
    parameter int ADDR_W = regfile_sequencer_pkg::ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    regfile_sequencer_if.slave  bus,
    output logic                o_done,
    output logic                o_flag_z,
    output logic                o_flag_c
);
    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_ra3;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_res_z;
    logic              r_res_c;
    logic              r_flag_z;
    logic              r_flag_c;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;
    logic              w_alu_zero;
    logic              w_ins_ready;
    logic              w_we3;
    logic              w_done;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ins_ready = 1'b0;
        w_we3       = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ins_ready = 1'b1;
                if (bus.ins_valid) w_next = S_READ;
            end
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: begin
                w_we3  = (r_op == OP_NOP);
                w_next = S_RETIRE;
            end
            S_RETIRE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= OP_NOP;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_ra3    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_res_z  <= 1'b0;
            r_res_c  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.ins_valid) begin
                r_op  <= op_e'(bus.ins_op);
                r_rd  <= bus.ins_rd;
                r_rs1 <= bus.ins_rs1;
                r_rs2 <= bus.ins_rs2;
                r_imm <= bus.ins_imm;
            end
            if (r_state == S_READ) begin
                r_a <= bus.rd1;
                r_b <= bus.rd2;
            end
            // RA3 only moves when a write is about to be presented
            if (r_state == S_EXEC) begin
                r_result <= w_alu_result;
                r_res_z  <= w_alu_zero;
                r_res_c  <= w_alu_carry;
                r_ra3    <= r_rd;
            end
            if (r_state == S_WRITE && (r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR})) begin
                r_flag_z <= r_res_z;
                r_flag_c <= r_res_c;
            end
        end
    end

    assign bus.ins_ready = w_ins_ready;
    assign bus.ra1       = r_rs1;
    assign bus.ra2       = r_rs2;
    assign bus.ra3       = r_ra3;
    assign bus.wd3       = r_result;
    assign bus.we3       = w_we3;
    assign o_done        = w_done;
    assign o_flag_z      = r_flag_z;
    assign o_flag_c      = r_flag_c;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer with a behavioural register file
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        logic z;
        logic c;
        int   cyc;
    } dn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic done;
    logic flag_z;
    logic flag_c;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    wr_t  wq[$];
    dn_t  dq[$];
    wr_t  we_exp;
    dn_t  dn_exp;
    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    regfile_sequencer_if bus ();

    regfile_sequencer dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus),
        .o_done   (done),
        .o_flag_z (flag_z),
        .o_flag_c (flag_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.we3 == 1'b0) rf[bus.ra3] <= bus.wd3;
    assign bus.rd1 = rf[bus.ra1];
    assign bus.rd2 = rf[bus.ra2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.we3 === 1'b0) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: ra3=%0d wd3=%0h expected no write", bus.ra3, bus.wd3);
            end else begin
                we_exp = wq.pop_front();
                check("wr_addr", 32'(bus.ra3), 32'(we_exp.addr));
                check("wr_data", 32'(bus.wd3), 32'(we_exp.data));
                check("wr_cycle", cyc, we_exp.cyc);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                dn_exp = dq.pop_front();
                check("flag_z", 32'(flag_z), 32'(dn_exp.z));
                check("flag_c", 32'(flag_c), 32'(dn_exp.c));
                check("done_cycle", cyc, dn_exp.cyc);
            end
        end
    end

    task automatic push(input op_e op, input logic [1:0] rd, input logic [7:0] wdata, input logic z, input logic c);
        wr_t w;
        dn_t d;
        if (op != OP_NOP) begin
            w.addr = rd; w.data = wdata; w.cyc = cyc + 3;
            wq.push_back(w);
        end
        d.z = z; d.c = c; d.cyc = cyc + 4;
        dq.push_back(d);
    endtask

    task automatic drive(input op_e op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        bus.ins_valid = 1'b1;
        bus.ins_op    = op;
        bus.ins_rd    = rd;
        bus.ins_rs1   = rs1;
        bus.ins_rs2   = rs2;
        bus.ins_imm   = imm;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (bus.ins_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 20);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ins_ready=%0b expected 1", bus.ins_ready);
            bus.ins_valid = 1'b0;
        end
    endtask

    task automatic issue(input op_e op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [7:0] imm, input logic [7:0] wdata, input logic z, input logic c);
        bit ok;
        @(negedge clk);
        drive(op, rd, rs1, rs2, imm);
        wait_ready(ok);
        if (ok) begin
            push(op, rd, wdata, z, c);
            @(posedge clk);
            #1 bus.ins_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", wq.size() + dq.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int we_lo;
        bit ok;
        bus.ins_valid = 1'b0;
        bus.ins_op    = 3'd0;
        bus.ins_rd    = 2'd0;
        bus.ins_rs1   = 2'd0;
        bus.ins_rs2   = 2'd0;
        bus.ins_imm   = 8'd0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ins_ready), 32'd1);
        check("rst_we3", 32'(bus.we3), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
        check("rst_addrs", {26'd0, bus.ra1, bus.ra2, bus.ra3}, 32'd0);
        check("rst_wd3", 32'(bus.wd3), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_spurious_accept", 32'(bus.ins_ready), 32'd1);

        issue(OP_MOVI, 2'd1, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1'b0);
        issue(OP_MOVI, 2'd2, 2'd0, 2'd0, 8'h03, 8'h03, 1'b0, 1'b0);
        issue(OP_ADD,  2'd3, 2'd1, 2'd2, 8'h00, 8'h08, 1'b0, 1'b0);
        drain();
        check("r3_add", 32'(rf[3]), 32'h08);

        issue(OP_MOVI, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        issue(OP_MOVI, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        issue(OP_ADD,  2'd2, 2'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b1);
        issue(OP_NOP,  2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        issue(OP_SUB,  2'd2, 2'd1, 2'd0, 8'h00, 8'h02, 1'b0, 1'b1);
        issue(OP_SUB,  2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        issue(OP_MOV,  2'd1, 2'd2, 2'd0, 8'h00, 8'h02, 1'b1, 1'b0);
        issue(OP_OR,   2'd3, 2'd2, 2'd1, 8'h00, 8'h02, 1'b0, 1'b0);
        issue(OP_AND,  2'd0, 2'd0, 2'd2, 8'h00, 8'h02, 1'b0, 1'b0);
        drain();
        check("r2_sub", 32'(rf[2]), 32'h02);
        check("r0_and", 32'(rf[0]), 32'h02);

        // continuous INS_VALID: the sequencer must pace acceptances every 5 cycles
        @(negedge clk);
        drive(OP_MOVI, 2'd2, 2'd0, 2'd0, 8'h77);
        acc = 0;
        we_lo = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ins_ready === 1'b1) begin
                acc++;
                push(OP_MOVI, 2'd2, 8'h77, 1'b0, 1'b0);
            end
            if (bus.we3 === 1'b0) we_lo++;
            @(negedge clk);
        end
        bus.ins_valid = 1'b0;
        check("stream_accepts", acc, 4);
        check("stream_we3_low", we_lo, 4);
        drain();
        check("r2_stream", 32'(rf[2]), 32'h77);

        @(negedge clk);
        drive(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
        wait_ready(ok);
        if (ok) begin
            @(posedge clk);
            #1 bus.ins_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("mid_rst_ready", 32'(bus.ins_ready), 32'd1);
            check("mid_rst_we3", 32'(bus.we3), 32'd1);
            check("mid_rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
            check("mid_rst_done", 32'(done), 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            check("r3_after_rst", 32'(rf[3]), 32'h02);
        end

        issue(OP_SUB,  2'd0, 2'd3, 2'd2, 8'h00, 8'h8B, 1'b0, 1'b1);
        issue(OP_NOP,  2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1);
        issue(OP_MOVI, 2'd1, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0, 1'b1);
        issue(OP_XOR,  2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0);
        drain();
        check("r1_xor", 32'(rf[1]), 32'h00);
        check("r0_sub_borrow", 32'(rf[0]), 32'h8B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter: DATA_W, 8, register and operand width.
REQ-002 Parameter: ADDR_W, 2, register address width (4 registers).
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 INS_VALID  input  1  instruction offered.
REQ-006 INS_READY  output  1  sequencer can accept an instruction.
REQ-007 INS_OP  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV (rd=rs1), 7 MOVI (rd=imm).
REQ-008 INS_RD, INS_RS1, INS_RS2  input  ADDR_W each  destination and source register addresses.
REQ-009 INS_IMM  input  DATA_W  immediate for MOVI.
REQ-010 RA1, RA2  output  ADDR_W each  register-file read addresses.
REQ-011 RD1, RD2  input  DATA_W each  register-file read data, combinational from RA1/RA2.
REQ-012 RA3  output  ADDR_W  register-file write address.
REQ-013 WD3  output  DATA_W  register-file write data.
REQ-014 WE3  output  1  register-file write enable, active-low (0 = write on the next rising CLK).
REQ-015 DONE  output  1  one-cycle pulse per retired instruction.
REQ-016 FLAG_Z, FLAG_C  output  1 each  zero and carry/borrow of the last retired ALU instruction.

Function
REQ-017 States: IDLE, READ, EXEC, WRITE, RETIRE; one state per cycle, no stalls after acceptance.
REQ-018 IDLE: INS_READY=1; an instruction is accepted on a rising edge with INS_VALID=1 and INS_READY=1, and opcode, addresses and immediate are captured; next state READ.
REQ-019 INS_READY is 0 in every state except IDLE; INS_VALID in other states is ignored.
REQ-020 READ: RA1=captured RS1, RA2=captured RS2; RD1/RD2 are registered into operand registers at the end of the cycle; next state EXEC.
REQ-021 EXEC: result = DATA_W-bit wrap-around of the operation; ADD carry = bit DATA_W of the (DATA_W+1)-bit sum; SUB C = 1 when RS1 < RS2 unsigned (borrow); AND/OR/XOR/MOV/MOVI C = 0; Z = (result == 0); result is registered; next state WRITE.
REQ-022 WRITE: RA3=captured RD, WD3=registered result, WE3=0 for exactly this one cycle; NOP keeps WE3=1; next state RETIRE.
REQ-023 RETIRE: DONE=1 for one cycle; FLAG_Z/FLAG_C update at the start of this cycle for opcodes 1-5 only and otherwise hold; next state IDLE.
REQ-024 Throughput: one instruction per 5 cycles; acceptance-to-DONE latency is 4 cycles.
REQ-025 WE3 is 1 in every state other than WRITE, including all reset conditions.
REQ-026 RS1 or RS2 equal to the RD of the previous instruction reads the written value, because that write completes before the next READ.
REQ-027 RD == RS1/RS2 within one instruction is legal; operands are captured in READ, before the WRITE cycle.
REQ-028 RA1/RA2/RA3/WD3 hold their last values outside the states that drive them.

Reset
REQ-029 RST_N=0 forces IDLE immediately, asynchronously, including mid-instruction; the in-flight instruction is discarded and never written.
REQ-030 Reset values: INS_READY=1, WE3=1, DONE=0, FLAG_Z=0, FLAG_C=0, RA1=RA2=RA3=0, WD3=0, and all internal registers 0.
REQ-031 No instruction is accepted on the first rising edge after RST_N deasserts, unless INS_VALID=1 is present at that edge.

Structure
REQ-032 A shared package holds the opcode enum, the state enum, DATA_W and ADDR_W.
REQ-033 The ALU is one sub-module, seq_alu: combinational; inputs op, a, b, imm; outputs result, carry, zero.
REQ-034 The FSM and all registers live in regfile_sequencer.

Verification
REQ-035 The bench connects regfile_sequencer to a behavioural 4x8 register file that uses the same active-low WE3 semantics.
REQ-036 Scenario: MOVI R1,0x05; MOVI R2,0x03; ADD R3,R1,R2 -> R3=0x08, Z=0, C=0, DONE pulses 4 cycles after each acceptance.
REQ-037 Scenario: MOVI R0,0xFF; MOVI R1,0x01; ADD R2,R0,R1 -> R2=0x00, Z=1, C=1.
REQ-038 Scenario: SUB R2,R1,R0 with R1=0x01, R0=0xFF -> R2=0x02, C=1 (borrow); SUB R3,R0,R0 -> R3=0x00, Z=1, C=0.
REQ-039 Scenario: INS_VALID held high for 20 cycles -> exactly 4 acceptances, INS_READY low between them, WE3 low exactly 1 cycle per non-NOP instruction.
REQ-040 Scenario: RST_N pulsed low during the EXEC of ADD R3 -> R3 unchanged, WE3 never 0, INS_READY=1 immediately, flags 0.
REQ-041 Scenario: NOP followed by XOR R1,R1,R1 (R1=0x5A) -> NOP gives DONE with no write and flags held; XOR leaves R1=0x00, Z=1.
